// File: rtl/game_pkg.sv
// Shared types and constants for the Tom & Jerry round sequencer, movers and HUD.
package game_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      COUNTDOWN = 3'd1,
      PLAY      = 3'd2,
      OVER      = 3'd3,
      MATCH_END = 3'd4
   } round_state_t;

   localparam logic [1:0] OVER_NONE  = 2'b00;
   localparam logic [1:0] OVER_TOM   = 2'b01;
   localparam logic [1:0] OVER_JERRY = 2'b10;

   localparam logic [3:0] SCORE_MAX  = 4'd9;

   function automatic logic [3:0] score_inc(input logic [3:0] score);
      return (score >= SCORE_MAX) ? SCORE_MAX : score + 4'd1;
   endfunction

endpackage

// File: rtl/game_round_ctrl_if.sv
// Control/status bundle between the round sequencer and the game top.
interface game_round_ctrl_if;
   logic       start;
   logic       restart;
   logic       catch_evt;
   logic       move_reset;
   logic [1:0] over;
   logic       round_active;
   logic       match_over;
   logic [1:0] count_left;
   logic [6:0] time_left;
   logic [3:0] tom_score;
   logic [3:0] jerry_score;

   modport master (
      output start, restart, catch_evt,
      input  move_reset, over, round_active, match_over,
      input  count_left, time_left, tom_score, jerry_score
   );

   modport slave (
      input  start, restart, catch_evt,
      output move_reset, over, round_active, match_over,
      output count_left, time_left, tom_score, jerry_score
   );
endinterface

// File: rtl/game_round_ctrl_sec_prescaler.sv
// One-second tick generator; clr restarts the second so the first tick
// lands exactly CLK_HZ cycles after it is released.
module sec_prescaler #(
   parameter int CLK_HZ = 65_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);
   localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

   logic [CW-1:0] r_cnt;
   logic          w_wrap;

   assign w_wrap = (r_cnt == CW'(CLK_HZ - 1));
   assign tick   = w_wrap;

   // Free-running cycle counter, wrapping once per second.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clr || w_wrap) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end
endmodule

// File: rtl/game_round_ctrl.sv
// Round/match sequencer: title -> countdown -> play -> round-over -> match end,
// with round timer and per-player scores, all outputs registered.
module game_round_ctrl
   import game_pkg::*;
#(
   parameter int CLK_HZ        = 65_000_000,
   parameter int COUNTDOWN_SEC = 3,
   parameter int ROUND_SEC     = 60,
   parameter int HOLD_SEC      = 2,
   parameter int WIN_ROUNDS    = 3
) (
   input  logic               clk,
   input  logic               rst,
   game_round_ctrl_if.slave   bus
);
   localparam int         HW      = $clog2(HOLD_SEC + 1);
   localparam logic [1:0] CD_LOAD = 2'(COUNTDOWN_SEC);
   localparam logic [6:0] RS_LOAD = 7'(ROUND_SEC);
   localparam logic [3:0] WIN_L   = 4'(WIN_ROUNDS);

   round_state_t r_state, w_state_next;
   logic          r_start_d, w_start_rise, w_tick, w_clr;
   logic [1:0]    r_count, w_count_next, r_over, w_over_next;
   logic [6:0]    r_time, w_time_next;
   logic [3:0]    r_tom, w_tom_next, r_jerry, w_jerry_next;
   logic [HW-1:0] r_hold, w_hold_next;
   logic          r_move_reset, r_round_active, r_match_over;

   assign w_start_rise = bus.start & ~r_start_d;
   assign w_clr        = (w_state_next != r_state);

   sec_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .clr  (w_clr),
      .tick (w_tick)
   );

   // Next-state, timer and score decisions; restart overrides everything.
   always_comb begin
      w_state_next = r_state;
      w_count_next = r_count;
      w_time_next  = r_time;
      w_tom_next   = r_tom;
      w_jerry_next = r_jerry;
      w_over_next  = r_over;
      w_hold_next  = r_hold;
      if (bus.restart) begin
         w_state_next = IDLE;
         w_count_next = CD_LOAD;
         w_time_next  = RS_LOAD;
         w_tom_next   = 4'd0;
         w_jerry_next = 4'd0;
         w_over_next  = OVER_NONE;
         w_hold_next  = '0;
      end else begin
         case (r_state)
            IDLE: begin
               w_over_next = OVER_NONE;
               if (w_start_rise) begin
                  w_state_next = COUNTDOWN;
                  w_count_next = CD_LOAD;
               end else begin
                  w_state_next = IDLE;
               end
            end
            COUNTDOWN: begin
               w_over_next = OVER_NONE;
               if (w_tick && (r_count == 2'd1)) begin
                  w_state_next = PLAY;
                  w_count_next = 2'd0;
                  w_time_next  = RS_LOAD;
               end else if (w_tick) begin
                  w_count_next = r_count - 2'd1;
               end else begin
                  w_count_next = r_count;
               end
            end
            PLAY: begin
               w_time_next = w_tick ? (r_time - 7'd1) : r_time;
               // A catch on the final tick still counts as Tom's round.
               if (bus.catch_evt) begin
                  w_state_next = OVER;
                  w_over_next  = OVER_TOM;
                  w_tom_next   = score_inc(r_tom);
                  w_hold_next  = '0;
               end else if (w_tick && (r_time == 7'd1)) begin
                  w_state_next = OVER;
                  w_over_next  = OVER_JERRY;
                  w_jerry_next = score_inc(r_jerry);
                  w_hold_next  = '0;
               end else begin
                  w_state_next = PLAY;
               end
            end
            OVER: begin
               if (w_tick && (r_hold == HW'(HOLD_SEC - 1))) begin
                  if ((r_tom == WIN_L) || (r_jerry == WIN_L)) begin
                     w_state_next = MATCH_END;
                  end else begin
                     w_state_next = COUNTDOWN;
                     w_count_next = CD_LOAD;
                     w_over_next  = OVER_NONE;
                  end
               end else if (w_tick) begin
                  w_hold_next = r_hold + HW'(1);
               end else begin
                  w_hold_next = r_hold;
               end
            end
            MATCH_END: begin
               if (w_start_rise) begin
                  w_state_next = COUNTDOWN;
                  w_count_next = CD_LOAD;
                  w_tom_next   = 4'd0;
                  w_jerry_next = 4'd0;
                  w_over_next  = OVER_NONE;
               end else begin
                  w_state_next = MATCH_END;
               end
            end
            default: begin
               w_state_next = IDLE;
               w_count_next = CD_LOAD;
               w_time_next  = RS_LOAD;
               w_tom_next   = 4'd0;
               w_jerry_next = 4'd0;
               w_over_next  = OVER_NONE;
               w_hold_next  = '0;
            end
         endcase
      end
   end

   // State, counters, scores and registered status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= IDLE;
         r_start_d      <= 1'b0;
         r_count        <= CD_LOAD;
         r_time         <= RS_LOAD;
         r_tom          <= 4'd0;
         r_jerry        <= 4'd0;
         r_over         <= OVER_NONE;
         r_hold         <= '0;
         r_move_reset   <= 1'b1;
         r_round_active <= 1'b0;
         r_match_over   <= 1'b0;
      end else begin
         r_state        <= w_state_next;
         r_start_d      <= bus.start;
         r_count        <= w_count_next;
         r_time         <= w_time_next;
         r_tom          <= w_tom_next;
         r_jerry        <= w_jerry_next;
         r_over         <= w_over_next;
         r_hold         <= w_hold_next;
         r_move_reset   <= (w_state_next == IDLE) || (w_state_next == COUNTDOWN);
         r_round_active <= (w_state_next == PLAY);
         r_match_over   <= (w_state_next == MATCH_END);
      end
   end

   assign bus.move_reset   = r_move_reset;
   assign bus.over         = r_over;
   assign bus.round_active = r_round_active;
   assign bus.match_over   = r_match_over;
   assign bus.count_left   = r_count;
   assign bus.time_left    = r_time;
   assign bus.tom_score    = r_tom;
   assign bus.jerry_score  = r_jerry;
endmodule

// File: tb/tb_game_round_ctrl.sv
// Bench for game_round_ctrl: a seconds-elapsed model checked every cycle plus
// hand-computed literal checkpoints along a directed match.
module tb_game_round_ctrl;
   localparam int HZ   = 10;
   localparam int CD   = 3;
   localparam int RS   = 5;
   localparam int HOLD = 2;
   localparam int WIN  = 2;
   localparam int P_IDLE = 0, P_CD = 1, P_PLAY = 2, P_OVER = 3, P_END = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   game_round_ctrl_if bus ();

   game_round_ctrl #(
      .CLK_HZ(HZ), .COUNTDOWN_SEC(CD), .ROUND_SEC(RS), .HOLD_SEC(HOLD), .WIN_ROUNDS(WIN)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: phase plus cycles since entering it; seconds elapsed = age / HZ.
   int   m_phase = P_IDLE, m_age = 0, m_cnt = CD, m_time = RS;
   int   m_tom = 0, m_jer = 0, m_over = 0;
   logic m_prev = 1'b0;

   always @(posedge clk or posedge rst) begin : model
      int p, age, cnt, tim, tom, jer, ovr, secs;
      logic rise;
      if (rst) begin
         m_phase <= P_IDLE; m_age <= 0; m_cnt <= CD; m_time <= RS;
         m_tom <= 0; m_jer <= 0; m_over <= 0; m_prev <= 1'b0;
      end else begin
         p = m_phase; age = m_age + 1; cnt = m_cnt; tim = m_time;
         tom = m_tom; jer = m_jer; ovr = m_over;
         secs = age / HZ;
         rise = bus.start && !m_prev;
         if (bus.restart) begin
            p = P_IDLE; age = 0; cnt = CD; tim = RS; tom = 0; jer = 0; ovr = 0;
         end else begin
            case (m_phase)
               P_IDLE: if (rise) begin p = P_CD; age = 0; cnt = CD; end
               P_CD: begin
                  if (secs >= CD) begin p = P_PLAY; age = 0; cnt = 0; tim = RS; end
                  else cnt = CD - secs;
               end
               P_PLAY: begin
                  tim = RS - secs;
                  if (bus.catch_evt) begin
                     p = P_OVER; age = 0; ovr = 1; tom = (tom < 9) ? tom + 1 : 9;
                  end else if (secs >= RS) begin
                     p = P_OVER; age = 0; ovr = 2; jer = (jer < 9) ? jer + 1 : 9;
                  end
               end
               P_OVER: begin
                  if (secs >= HOLD) begin
                     age = 0;
                     if (tom == WIN || jer == WIN) p = P_END;
                     else begin p = P_CD; cnt = CD; ovr = 0; end
                  end
               end
               P_END: if (rise) begin p = P_CD; age = 0; cnt = CD; tom = 0; jer = 0; ovr = 0; end
               default: p = P_IDLE;
            endcase
         end
         m_phase <= p; m_age <= age; m_cnt <= cnt; m_time <= tim;
         m_tom <= tom; m_jer <= jer; m_over <= ovr; m_prev <= bus.start;
      end
   end

   // Every cycle, on the falling edge, compare all outputs to the model.
   always @(negedge clk) begin
      chk("move_reset", int'(bus.move_reset), int'(m_phase == P_IDLE || m_phase == P_CD));
      chk("round_active", int'(bus.round_active), int'(m_phase == P_PLAY));
      chk("match_over", int'(bus.match_over), int'(m_phase == P_END));
      chk("over", int'(bus.over), m_over);
      chk("count_left", int'(bus.count_left), m_cnt);
      chk("time_left", int'(bus.time_left), m_time);
      chk("tom_score", int'(bus.tom_score), m_tom);
      chk("jerry_score", int'(bus.jerry_score), m_jer);
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      bus.start = 1'b0; bus.restart = 1'b0; bus.catch_evt = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_move_reset", int'(bus.move_reset), 1);
      chk("rst_count", int'(bus.count_left), 3);
      chk("rst_time", int'(bus.time_left), 5);
      chk("rst_over", int'(bus.over), 0);

      // Countdown 3,2,1 then PLAY 30 cycles after the start edge.
      bus.start = 1'b1; step(1); bus.start = 1'b0;
      chk("cd_3", int'(bus.count_left), 3);
      step(9);  chk("cd_3_hold", int'(bus.count_left), 3);
      step(1);  chk("cd_2", int'(bus.count_left), 2);
      step(10); chk("cd_1", int'(bus.count_left), 1);
      step(10); chk("play_active", int'(bus.round_active), 1);
      chk("play_move_reset", int'(bus.move_reset), 0);
      chk("play_time", int'(bus.time_left), 5);

      // Timeout: Jerry takes the round.
      step(10); chk("time_4", int'(bus.time_left), 4);
      step(40); chk("to_over", int'(bus.over), 2);
      chk("to_jerry", int'(bus.jerry_score), 1);
      chk("to_time", int'(bus.time_left), 0);
      step(19); chk("hold_over", int'(bus.over), 2);
      step(1);  chk("hold_done_over", int'(bus.over), 0);
      chk("hold_done_mr", int'(bus.move_reset), 1);

      // Catch on the final tick: Tom wins.
      step(79); chk("final_sec", int'(bus.time_left), 1);
      bus.catch_evt = 1'b1; step(1); bus.catch_evt = 1'b0;
      chk("tie_over", int'(bus.over), 1);
      chk("tie_tom", int'(bus.tom_score), 1);
      chk("tie_jerry", int'(bus.jerry_score), 1);
      step(5); bus.catch_evt = 1'b1; step(1); bus.catch_evt = 1'b0;
      chk("over_catch_ignored", int'(bus.tom_score), 1);
      step(14); chk("cd_again", int'(bus.count_left), 3);

      // Second Tom win ends the match.
      step(35); bus.catch_evt = 1'b1; step(1); bus.catch_evt = 1'b0;
      chk("win2_tom", int'(bus.tom_score), 2);
      step(24); chk("match_over", int'(bus.match_over), 1);
      chk("match_over_flag", int'(bus.over), 1);
      bus.catch_evt = 1'b1; step(1); bus.catch_evt = 1'b0;
      bus.start = 1'b1; step(1); bus.start = 1'b0;
      chk("new_match_tom", int'(bus.tom_score), 0);
      chk("new_match_jerry", int'(bus.jerry_score), 0);
      chk("new_match_mo", int'(bus.match_over), 0);

      // Score a round, then restart with start mid-PLAY.
      step(34); bus.catch_evt = 1'b1; step(1); bus.catch_evt = 1'b0;
      chk("r_tom", int'(bus.tom_score), 1);
      step(55); chk("r_play", int'(bus.round_active), 1);
      bus.restart = 1'b1; bus.start = 1'b1; step(1); bus.restart = 1'b0;
      chk("restart_mr", int'(bus.move_reset), 1);
      chk("restart_tom", int'(bus.tom_score), 0);
      chk("restart_time", int'(bus.time_left), 5);
      step(1); bus.start = 1'b0;
      step(14); chk("restart_stays_idle", int'(bus.move_reset), 1);
      chk("restart_count", int'(bus.count_left), 3);

      // Catch ignored in IDLE and COUNTDOWN, then async reset mid-PLAY.
      bus.catch_evt = 1'b1; step(1); bus.catch_evt = 1'b0;
      chk("idle_catch", int'(bus.tom_score), 0);
      bus.start = 1'b1; step(1); bus.start = 1'b0;
      step(5); bus.catch_evt = 1'b1; step(1); bus.catch_evt = 1'b0;
      chk("cd_catch", int'(bus.tom_score), 0);
      step(30); chk("pre_rst_play", int'(bus.round_active), 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_active", int'(bus.round_active), 0);
      chk("arst_mr", int'(bus.move_reset), 1);
      chk("arst_count", int'(bus.count_left), 3);
      step(2); rst = 1'b0;
      step(3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
